// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - opcode/UART inputs and datapath control outputs of the main controller
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic       uart_done;
  logic       pcwrite;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       pcbufwrite;
  logic       iord;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] regsrc;
  logic [1:0] pcsrc;
  logic       branch;
  logic [2:0] aluop;
  logic       rors;
  logic       uart_go;
  logic       illegal;
  logic       uart_timeout;

  modport master (
    input  op, uart_done,
    output pcwrite, memwrite, irwrite, regwrite, pcbufwrite, iord,
    output alusrca, alusrcb, regsrc, pcsrc, branch, aluop,
    output rors, uart_go, illegal, uart_timeout
  );

  modport slave (
    output op, uart_done,
    input  pcwrite, memwrite, irwrite, regwrite, pcbufwrite, iord,
    input  alusrca, alusrcb, regsrc, pcsrc, branch, aluop,
    input  rors, uart_go, illegal, uart_timeout
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV32I core with UART byte ops
module multicycle_ctrl #(
  parameter int MEM_LAT      = 2,
  parameter int UART_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rstn,
  multicycle_ctrl_if.master   bus
);
  localparam int CMAX = (MEM_LAT > UART_TIMEOUT) ? MEM_LAT : UART_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FW_LAST = CW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [CW-1:0] MR_LAST = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] UT_LAST = CW'((UART_TIMEOUT > 0) ? UART_TIMEOUT - 1 : 0);

  localparam logic [6:0] OP_RTYPE = 7'b0110011, OP_ITYPE = 7'b0010011, OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LW    = 7'b0000011, OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RECVB = 7'b0000001, OP_SENDB = 7'b0000010;

  typedef enum logic [4:0] {
    IDLE, FETCH, FWAIT, FLATCH, DECODE, MEMADR, MREAD, MWB, MWRITE,
    EXECUTE, ALUWB, BRANCH, IMMEX, IMMWB, LUIEX, AUIPCEX, JALEX, JALREX,
    SENDB_GO, RECVB_GO, SENDB_WAIT, RECVB_WAIT, RECVB_WRITE, ILLEGAL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          started_q;
  logic          uart_wait, counting, to_hit;

  assign uart_wait = (state_q == SENDB_WAIT) || (state_q == RECVB_WAIT);
  assign counting  = (state_q == FWAIT) || (state_q == MREAD) || uart_wait;
  // uart_done in the same cycle always beats the timeout
  assign to_hit    = (UART_TIMEOUT > 0) && uart_wait && (cnt_q == UT_LAST) && !bus.uart_done;
  assign cnt_d     = (counting && (state_d == state_q)) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (started_q) state_d = FETCH;
      FETCH:   state_d = (MEM_LAT == 1) ? FLATCH : FWAIT;
      FWAIT:   if (cnt_q == FW_LAST) state_d = FLATCH;
      FLATCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BTYPE:     state_d = BRANCH;
          OP_ITYPE:     state_d = IMMEX;
          OP_LUI:       state_d = LUIEX;
          OP_AUIPC:     state_d = AUIPCEX;
          OP_JAL:       state_d = JALEX;
          OP_JALR:      state_d = JALREX;
          OP_RECVB:     state_d = RECVB_GO;
          OP_SENDB:     state_d = SENDB_GO;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_LW) ? MREAD : MWRITE;
      MREAD:   if (cnt_q == MR_LAST) state_d = MWB;
      EXECUTE: state_d = ALUWB;
      IMMEX:   state_d = IMMWB;
      SENDB_GO: state_d = SENDB_WAIT;
      RECVB_GO: state_d = RECVB_WAIT;
      SENDB_WAIT: if (bus.uart_done || to_hit) state_d = FETCH;
      RECVB_WAIT: begin
        if (bus.uart_done)  state_d = RECVB_WRITE;
        else if (to_hit)    state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.pcwrite = 1'b0; bus.memwrite = 1'b0; bus.irwrite = 1'b0; bus.regwrite = 1'b0;
    bus.pcbufwrite = 1'b0; bus.iord = 1'b0; bus.alusrca = 2'b00; bus.alusrcb = 2'b00;
    bus.regsrc = 3'b000; bus.pcsrc = 2'b00; bus.branch = 1'b0; bus.aluop = 3'b000;
    bus.rors = 1'b0; bus.uart_go = 1'b0;
    bus.illegal = (state_q == ILLEGAL);
    bus.uart_timeout = to_hit;
    case (state_q)
      FETCH:   begin bus.pcwrite = 1'b1; bus.pcbufwrite = 1'b1; bus.alusrcb = 2'b01; end
      FLATCH:  bus.irwrite = 1'b1;
      DECODE:  begin bus.alusrca = 2'b01; bus.alusrcb = 2'b10; end
      MEMADR:  begin bus.alusrca = 2'b10; bus.alusrcb = 2'b10; end
      MREAD:   bus.iord = 1'b1;
      MWB:     begin bus.regwrite = 1'b1; bus.regsrc = 3'b001; end
      MWRITE:  begin bus.memwrite = 1'b1; bus.iord = 1'b1; end
      EXECUTE: begin bus.alusrca = 2'b10; bus.aluop = 3'b100; end
      ALUWB, IMMWB, AUIPCEX: bus.regwrite = 1'b1;
      BRANCH:  begin bus.alusrca = 2'b10; bus.pcsrc = 2'b01; bus.branch = 1'b1; bus.aluop = 3'b111; end
      IMMEX:   begin bus.alusrca = 2'b10; bus.alusrcb = 2'b10; bus.aluop = 3'b101; end
      LUIEX:   begin bus.regwrite = 1'b1; bus.regsrc = 3'b010; end
      JALEX:   begin bus.pcwrite = 1'b1; bus.regwrite = 1'b1; bus.regsrc = 3'b011; bus.pcsrc = 2'b01; end
      JALREX: begin
        bus.pcwrite = 1'b1; bus.regwrite = 1'b1; bus.alusrca = 2'b10; bus.alusrcb = 2'b10;
        bus.regsrc = 3'b011; bus.pcsrc = 2'b10;
      end
      SENDB_GO:    begin bus.rors = 1'b1; bus.uart_go = 1'b1; end
      RECVB_GO:    bus.uart_go = 1'b1;
      RECVB_WRITE: begin bus.regwrite = 1'b1; bus.regsrc = 3'b100; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized and directed checks of multicycle_ctrl against a sequence model
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcbufwrite;
    logic       iord;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] regsrc;
    logic [1:0] pcsrc;
    logic       branch;
    logic [2:0] aluop;
    logic       rors;
    logic       uart_go;
    logic       illegal;
    logic       uart_timeout;
  } o_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011, OP_ITYPE = 7'b0010011, OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LW    = 7'b0000011, OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RECVB = 7'b0000001, OP_SENDB = 7'b0000010;

  function automatic int ml_of(input int k);
    case (k) 0: return 2; 1: return 1; 2: return 3; default: return 15; endcase
  endfunction
  function automatic int to_of(input int k);
    case (k) 0: return 5; 1: return 0; 2: return 0; default: return 1; endcase
  endfunction

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [6:0]  op_drv   [4];
  logic        done_drv [4];
  logic [22:0] got_v    [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    multicycle_ctrl_if bus ();
    multicycle_ctrl #(.MEM_LAT(ml_of(g)), .UART_TIMEOUT(to_of(g))) u_dut (
      .clk(clk), .rstn(rstn), .bus(bus)
    );
    assign bus.op        = op_drv[g];
    assign bus.uart_done = done_drv[g];
    assign got_v[g] = {bus.pcwrite, bus.memwrite, bus.irwrite, bus.regwrite, bus.pcbufwrite,
                       bus.iord, bus.alusrca, bus.alusrcb, bus.regsrc, bus.pcsrc, bus.branch,
                       bus.aluop, bus.rors, bus.uart_go, bus.illegal, bus.uart_timeout};
  end

  int n_cmp = 0, n_mis = 0;
  int cyc = 0, last_fetch = 0, last_period = 0;
  int c_iord, c_irw, c_ill, c_to, c_regw, c_mem, c_go, c_rors;

  o_t         q_e [$];
  logic [6:0] q_o [$];
  logic       q_d [$];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic push(input o_t e, input logic [6:0] o, input logic d);
    q_e.push_back(e); q_o.push_back(o); q_d.push_back(d);
  endtask

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Expected per-cycle outputs for one whole instruction, FETCH first.
  // wk = wait cycles before uart_done arrives, gd = uart_done level during GO.
  task automatic build(input int ml, input int to, input logic [6:0] op, input int wk, input logic gd);
    o_t e;
    q_e.delete(); q_o.delete(); q_d.delete();
    e = '0; e.pcwrite = 1; e.pcbufwrite = 1; e.alusrcb = 2'b01; push(e, rop(), 1'($urandom));
    for (int i = 0; i < ml - 1; i++) begin e = '0; push(e, rop(), 1'($urandom)); end
    e = '0; e.irwrite = 1; push(e, rop(), 1'($urandom));
    e = '0; e.alusrca = 2'b01; e.alusrcb = 2'b10; push(e, op, 1'($urandom));
    e = '0;
    case (op)
      OP_LW, OP_SW: begin
        e.alusrca = 2'b10; e.alusrcb = 2'b10; push(e, op, 1'($urandom));
        if (op == OP_LW) begin
          for (int i = 0; i < ml; i++) begin e = '0; e.iord = 1; push(e, rop(), 1'($urandom)); end
          e = '0; e.regwrite = 1; e.regsrc = 3'b001; push(e, rop(), 1'($urandom));
        end else begin
          e = '0; e.memwrite = 1; e.iord = 1; push(e, rop(), 1'($urandom));
        end
      end
      OP_RTYPE: begin
        e.alusrca = 2'b10; e.aluop = 3'b100; push(e, rop(), 1'($urandom));
        e = '0; e.regwrite = 1; push(e, rop(), 1'($urandom));
      end
      OP_ITYPE: begin
        e.alusrca = 2'b10; e.alusrcb = 2'b10; e.aluop = 3'b101; push(e, rop(), 1'($urandom));
        e = '0; e.regwrite = 1; push(e, rop(), 1'($urandom));
      end
      OP_BTYPE: begin
        e.alusrca = 2'b10; e.pcsrc = 2'b01; e.branch = 1; e.aluop = 3'b111; push(e, rop(), 1'($urandom));
      end
      OP_LUI:   begin e.regwrite = 1; e.regsrc = 3'b010; push(e, rop(), 1'($urandom)); end
      OP_AUIPC: begin e.regwrite = 1; push(e, rop(), 1'($urandom)); end
      OP_JAL: begin
        e.pcwrite = 1; e.regwrite = 1; e.regsrc = 3'b011; e.pcsrc = 2'b01; push(e, rop(), 1'($urandom));
      end
      OP_JALR: begin
        e.pcwrite = 1; e.regwrite = 1; e.alusrca = 2'b10; e.alusrcb = 2'b10;
        e.regsrc = 3'b011; e.pcsrc = 2'b10; push(e, rop(), 1'($urandom));
      end
      OP_RECVB, OP_SENDB: begin
        e.uart_go = 1; e.rors = (op == OP_SENDB); push(e, rop(), gd);
        if (to > 0 && wk >= to) begin
          for (int i = 0; i < to - 1; i++) begin e = '0; push(e, rop(), 1'b0); end
          e = '0; e.uart_timeout = 1; push(e, rop(), 1'b0);
        end else begin
          for (int i = 0; i < wk; i++) begin e = '0; push(e, rop(), 1'b0); end
          e = '0; push(e, rop(), 1'b1);
          if (op == OP_RECVB) begin
            e = '0; e.regwrite = 1; e.regsrc = 3'b100; push(e, rop(), 1'($urandom));
          end
        end
      end
      default: begin e.illegal = 1; push(e, rop(), 1'($urandom)); end
    endcase
  endtask

  task automatic cmp_out(input int k, input o_t e);
    o_t g;
    g = o_t'(got_v[k]);
    cyc++;
    n_cmp++;
    if (g !== e) begin
      n_mis++;
      $display("FAIL outputs dut%0d cyc%0d got=%h exp=%h", k, cyc, g, e);
    end
    c_iord += int'(g.iord); c_irw += int'(g.irwrite); c_ill += int'(g.illegal);
    c_to += int'(g.uart_timeout); c_regw += int'(g.regwrite); c_mem += int'(g.memwrite);
    c_go += int'(g.uart_go); c_rors += int'(g.rors);
    if (g.pcbufwrite) begin last_period = cyc - last_fetch; last_fetch = cyc; end
  endtask

  task automatic step(input int k, input o_t e, input logic [6:0] o, input logic d);
    @(negedge clk);
    op_drv[k] = o; done_drv[k] = d;
    #1;
    cmp_out(k, e);
  endtask

  task automatic run_instr(input int k, input logic [6:0] op, input int wk, input logic gd, input int nmax);
    build(ml_of(k), to_of(k), op, wk, gd);
    c_iord = 0; c_irw = 0; c_ill = 0; c_to = 0; c_regw = 0; c_mem = 0; c_go = 0; c_rors = 0;
    for (int i = 0; i < q_e.size(); i++) begin
      if (nmax >= 0 && i >= nmax) break;
      step(k, q_e[i], q_o[i], q_d[i]);
    end
  endtask

  task automatic do_reset(input int k);
    rstn = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) chk($sformatf("reset_zero_dut%0d", j), int'(got_v[j]), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    op_drv[k] = rop(); done_drv[k] = 1'b1;
    #1;
    cmp_out(k, '0);
    last_fetch = cyc;
    step(k, '0, rop(), 1'b1);
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] tbl [11];
    int idx;
    tbl = '{OP_RTYPE, OP_ITYPE, OP_BTYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LW, OP_SW, OP_RECVB, OP_SENDB};
    idx = $urandom_range(0, 12);
    return (idx < 11) ? tbl[idx] : rop();
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < 4; j++) begin op_drv[j] = '0; done_drv[j] = 1'b0; end

    // reset mid-DECODE, then first FETCH two edges after release
    do_reset(0);
    run_instr(0, OP_ITYPE, 0, 0, -1);
    run_instr(0, OP_RTYPE, 0, 0, 4);
    do_reset(0);
    run_instr(0, OP_ITYPE, 0, 0, -1);
    chk("fetch_after_release", last_period, 2);
    chk("addi_irwrite_ml2", c_irw, 1);

    do_reset(2);
    run_instr(2, OP_ITYPE, 0, 0, -1);
    run_instr(2, OP_ITYPE, 0, 0, -1);
    chk("addi_period_ml3", last_period, 7);
    chk("addi_irwrite_ml3", c_irw, 1);

    do_reset(1);
    run_instr(1, OP_ITYPE, 0, 0, -1);
    run_instr(1, OP_ITYPE, 0, 0, -1);
    chk("addi_period_ml1", last_period, 5);

    do_reset(0);
    run_instr(0, OP_LW, 0, 0, -1);
    chk("lw_iord_cycles", c_iord, 2);
    chk("lw_regwrite", c_regw, 1);
    run_instr(0, OP_ITYPE, 0, 0, -1);
    chk("lw_period", last_period, 8);

    run_instr(0, 7'b1111111, 0, 0, -1);
    chk("illegal_pulse", c_ill, 1);
    chk("illegal_regwrite", c_regw, 0);
    chk("illegal_memwrite", c_mem, 0);
    run_instr(0, OP_ITYPE, 0, 0, -1);
    chk("illegal_period", last_period, 5);

    run_instr(0, OP_RECVB, 9, 1, -1);
    chk("recvb_timeout_pulse", c_to, 1);
    chk("recvb_timeout_regwrite", c_regw, 0);
    run_instr(0, OP_ITYPE, 0, 0, -1);
    chk("recvb_timeout_period", last_period, 10);
    run_instr(0, OP_RECVB, 4, 0, -1);
    chk("recvb_late_done_timeout", c_to, 0);
    chk("recvb_late_done_regwrite", c_regw, 1);
    run_instr(0, OP_ITYPE, 0, 0, -1);
    chk("recvb_late_done_period", last_period, 11);

    do_reset(1);
    run_instr(1, OP_SENDB, 999, 1, -1);
    chk("sendb_uart_go", c_go, 1);
    chk("sendb_rors", c_rors, 1);
    run_instr(1, OP_ITYPE, 0, 0, -1);
    chk("sendb_period", last_period, 1004);

    for (int k = 0; k < 4; k++) begin
      do_reset(k);
      for (int n = 0; n < 30; n++) begin
        int wk;
        wk = (to_of(k) > 0) ? int'($urandom_range(0, to_of(k) + 2)) : int'($urandom_range(0, 15));
        run_instr(k, pick_op(), wk, 1'($urandom), -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
